bn_fwd_arbiter: RTL and testbench

- Round-robin arbiter that shares one batch-norm forward unit among NREQ requesters.
- Muxes the granted requester's batch, num, gamma and beta onto the unit.
- Sequences the unit's input_ready / done / output_taken handshake.
- Broadcasts the unit's results on a shared response bus with a per-requester valid.
- Sits between the layer-level channel engines and the single forward instance.

---
 rtl/bn_pkg.sv | 10 +
 rtl/bn_fwd_arbiter_rr_pick.sv | 23 ++
 rtl/bn_fwd_arbiter.sv | 114 +++++++++++
 tb/tb_bn_fwd_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bn_pkg.sv
// bn_pkg: shared word type, arbiter FSM states and forward-unit state encodings.
package bn_pkg;
    localparam int BN_IL = 8;
    localparam int BN_FL = 12;
    typedef logic signed [BN_IL+BN_FL-1:0] fx_t;
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} arb_state_t;
    localparam logic [1:0] FWD_IDLE = 2'b00;
    localparam logic [1:0] FWD_RUN = 2'b01;
    localparam logic [1:0] FWD_OUT = 2'b10;
endpackage

// File: rtl/bn_fwd_arbiter_rr_pick.sv
// rr_pick: picks the first asserted request at or after the pointer, in circular order.
module rr_pick #(
    parameter int N = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] pointer_i,
    output logic [GW-1:0] index_o,
    output logic          any_o
);
    logic hit;
    always_comb begin
        index_o = '0;
        hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!hit && req_i[(int'(pointer_i) + k) % N]) begin
                index_o = GW'((int'(pointer_i) + k) % N);
                hit = 1'b1;
            end
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/bn_fwd_arbiter.sv
// bn_fwd_arbiter: round-robin sharing of one batch-norm forward unit among NREQ requesters.
// Define BN_FWD_ARB_STATS_EN to add per-requester saturating completion counters (stats_grants).
module bn_fwd_arbiter
    import bn_pkg::*;
#(
    parameter int IL = 8,
    parameter int FL = 12,
    parameter int size = 16,
    parameter int NREQ = 4,
    parameter int GW = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic signed [IL+FL-1:0] req_batch [NREQ][size],
    input  logic [4:0]              req_num [NREQ],
    input  logic signed [IL+FL-1:0] req_gamma [NREQ],
    input  logic signed [IL+FL-1:0] req_beta [NREQ],
    input  logic [NREQ-1:0]         resp_taken,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         resp_valid,
    output logic signed [IL+FL-1:0] resp_out [size],
    output logic signed [IL+FL-1:0] resp_norm [size],
    output logic signed [IL+FL-1:0] resp_mu,
    output logic signed [IL+FL-1:0] resp_vari,
    output logic signed [IL+FL-1:0] fwd_batch [size],
    output logic [4:0]              fwd_num,
    output logic signed [IL+FL-1:0] fwd_gamma,
    output logic signed [IL+FL-1:0] fwd_beta,
    output logic                    fwd_input_ready,
    output logic                    fwd_output_taken,
    input  logic [1:0]              fwd_state,
    input  logic                    fwd_done,
    input  logic signed [IL+FL-1:0] fwd_out [size],
    input  logic signed [IL+FL-1:0] fwd_norm [size],
    input  logic signed [IL+FL-1:0] fwd_mu,
    input  logic signed [IL+FL-1:0] fwd_vari
`ifdef BN_FWD_ARB_STATS_EN
    ,
    output logic [15:0]             stats_grants [NREQ]
`endif
);
    arb_state_t state_q;
    logic [GW-1:0] gidx_q, ptr_q, pick;
    logic [NREQ-1:0] grant_q, valid_q;
    logic ir_q, any, take;

    rr_pick #(.N(NREQ), .GW(GW)) u_pick (
        .req_i(req),
        .pointer_i(ptr_q),
        .index_o(pick),
        .any_o(any)
    );

    assign take = (state_q == RESP) && resp_taken[gidx_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gidx_q <= '0;
            ptr_q <= '0;
            grant_q <= '0;
            valid_q <= '0;
            ir_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (any) begin
                    gidx_q <= pick;
                    grant_q <= NREQ'(1) << pick;
                    ir_q <= 1'b1;
                    state_q <= ISSUE;
                end
                // the unit latches its inputs on the cycle it reports idle with input_ready high
                ISSUE: if (fwd_state == FWD_IDLE) begin
                    ir_q <= 1'b0;
                    state_q <= BUSY;
                end
                BUSY: if (fwd_done) begin
                    valid_q <= NREQ'(1) << gidx_q;
                    state_q <= RESP;
                end
                RESP: if (take) begin
                    valid_q <= '0;
                    grant_q <= '0;
                    ptr_q <= (gidx_q == GW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant = grant_q;
    assign resp_valid = valid_q;
    assign fwd_input_ready = ir_q;
    assign fwd_output_taken = take;
    assign fwd_batch = req_batch[gidx_q];
    assign fwd_num = req_num[gidx_q];
    assign fwd_gamma = req_gamma[gidx_q];
    assign fwd_beta = req_beta[gidx_q];
    assign resp_out = fwd_out;
    assign resp_norm = fwd_norm;
    assign resp_mu = fwd_mu;
    assign resp_vari = fwd_vari;

`ifdef BN_FWD_ARB_STATS_EN
    logic [15:0] stats_q [NREQ];
    always_ff @(posedge clk) begin
        if (reset) stats_q <= '{default: '0};
        else if (take && stats_q[gidx_q] != 16'hFFFF) stats_q[gidx_q] <= stats_q[gidx_q] + 16'd1;
    end
    assign stats_grants = stats_q;
`endif
endmodule

// File: tb/tb_bn_fwd_arbiter.sv
// tb_bn_fwd_arbiter: directed stimulus against a stub forward unit, scoreboarded responses.
module tb_bn_fwd_arbiter;
    import bn_pkg::*;
    logic clk, reset;
    logic [3:0] req, resp_taken, grant, resp_valid;
    fx_t req_batch [4][16];
    logic [4:0] req_num [4];
    fx_t req_gamma [4], req_beta [4];
    fx_t resp_out [16], resp_norm [16], fwd_batch [16], fwd_out [16], fwd_norm [16];
    fx_t resp_mu, resp_vari, fwd_gamma, fwd_beta, fwd_mu, fwd_vari;
    logic [4:0] fwd_num;
    logic fwd_input_ready, fwd_output_taken, fwd_done;
    logic [1:0] fwd_state;
    logic [15:0] stats_grants [4];
    fx_t u_batch [16];
    fx_t u_gamma, u_beta;
    int total = 0, bad = 0;
    int exp_q [$];
    logic [3:0] prev_rv = '0;

    bn_fwd_arbiter dut (
`ifdef BN_FWD_ARB_STATS_EN
        .stats_grants(stats_grants),
`endif
        .clk(clk), .reset(reset), .req(req), .req_batch(req_batch), .req_num(req_num),
        .req_gamma(req_gamma), .req_beta(req_beta), .resp_taken(resp_taken),
        .grant(grant), .resp_valid(resp_valid), .resp_out(resp_out), .resp_norm(resp_norm),
        .resp_mu(resp_mu), .resp_vari(resp_vari), .fwd_batch(fwd_batch), .fwd_num(fwd_num),
        .fwd_gamma(fwd_gamma), .fwd_beta(fwd_beta), .fwd_input_ready(fwd_input_ready),
        .fwd_output_taken(fwd_output_taken), .fwd_state(fwd_state), .fwd_done(fwd_done),
        .fwd_out(fwd_out), .fwd_norm(fwd_norm), .fwd_mu(fwd_mu), .fwd_vari(fwd_vari)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stub unit: captures the muxed request when it accepts, replays it as results
    always @(posedge clk) begin
        if (fwd_input_ready && fwd_state == 2'b00) begin
            u_batch <= fwd_batch;
            u_gamma <= fwd_gamma;
            u_beta <= fwd_beta;
        end
    end
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            fwd_out[i] = u_batch[i];
            fwd_norm[i] = u_batch[15-i];
        end
        fwd_mu = u_gamma;
        fwd_vari = u_beta;
    end

    function automatic fx_t gam(input int r); return fx_t'((r + 1) << 12); endfunction
    function automatic fx_t bet(input int r); return fx_t'(-((r + 1) << 8)); endfunction
    function automatic fx_t bat(input int r, input int i); return fx_t'(4096 * (r + 1) + r * i); endfunction

    task automatic chk(input string n, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (resp_valid != 0 && prev_rv == 0) begin
            if (exp_q.size() == 0) chk("mon_unexpected", int'(resp_valid), 0);
            else begin
                automatic int e = exp_q.pop_front();
                chk("m_valid", int'(resp_valid), 1 << e);
                chk("m_grant", int'(grant), 1 << e);
                chk("m_mu", resp_mu, gam(e));
                chk("m_vari", resp_vari, bet(e));
                chk("m_out3", resp_out[3], bat(e, 3));
                chk("m_norm0", resp_norm[0], bat(e, 15));
            end
        end
        prev_rv <= resp_valid;
    end

    task automatic txn(input int e, input int stall, input int late, input logic drop);
        int t, ir;
        exp_q.push_back(e);
        fwd_state = stall > 0 ? 2'b10 : 2'b00;
        fwd_done = stall > 0;
        t = 0;
        while (grant == '0 && t < 20) begin step(); t++; end
        chk("grant", int'(grant), 1 << e);
        chk("grant_lat", t, 1);
        chk("fwd_num", int'(fwd_num), 16 - e);
        chk("fwd_gamma", fwd_gamma, gam(e));
        if (drop) req = '0;
        ir = 0;
        for (int c = 0; c < stall; c++) begin ir += int'(fwd_input_ready); step(); end
        fwd_state = 2'b00;
        fwd_done = 1'b0;
        ir += int'(fwd_input_ready);
        step();
        chk("ir_cycles", ir, stall + 1);
        chk("ir_drop", int'(fwd_input_ready), 0);
        fwd_state = 2'b01;
        step();
        step();
        chk("busy_no_valid", int'(resp_valid), 0);
        fwd_done = 1'b1;
        step();
        fwd_done = 1'b0;
        fwd_state = 2'b10;
        chk("resp_valid", int'(resp_valid), 1 << e);
        for (int c = 0; c < late; c++) begin
            resp_taken = 4'(1 << ((e + 1) % 4));
            #1;
            chk("late_valid", int'(resp_valid), 1 << e);
            chk("late_no_taken", int'(fwd_output_taken), 0);
            step();
        end
        resp_taken = 4'(1 << e);
        #1;
        chk("out_taken", int'(fwd_output_taken), 1);
        step();
        resp_taken = '0;
        fwd_state = 2'b00;
        chk("release", int'({grant, resp_valid}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset = 1'b1; req = '0; resp_taken = '0; fwd_state = 2'b00; fwd_done = 1'b0;
        for (int r = 0; r < 4; r++) begin
            req_num[r] = 5'(16 - r);
            req_gamma[r] = gam(r);
            req_beta[r] = bet(r);
            for (int i = 0; i < 16; i++) req_batch[r][i] = bat(r, i);
        end
        step(); step();
        reset = 1'b0;
        chk("rst_grant", int'(grant), 0);
        chk("rst_valid", int'(resp_valid), 0);
        chk("rst_ir", int'(fwd_input_ready), 0);
        chk("rst_taken", int'(fwd_output_taken), 0);
        step();
        req = 4'b0001; txn(0, 0, 0, 1'b0); req = '0;
        step();
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 8; k++) txn(k % 4, 0, 0, 1'b0);
        req = 4'b0100; txn(2, 0, 0, 1'b0);
        req = 4'b0101; txn(0, 0, 0, 1'b0);
        req = 4'b0100; txn(2, 0, 0, 1'b0);
        req = 4'b0010; txn(1, 3, 0, 1'b1);
        req = 4'b0001; txn(0, 0, 5, 1'b0); req = '0;
        step();
        req = 4'b1000;
        t = 0;
        while (grant == '0 && t < 20) begin step(); t++; end
        chk("abort_grant", int'(grant), 8);
        step();
        req = '0; fwd_state = 2'b01;
        step();
        reset = 1'b1; step(); reset = 1'b0; fwd_state = 2'b00;
        chk("abort_grant0", int'(grant), 0);
        chk("abort_valid0", int'(resp_valid), 0);
        chk("abort_ir0", int'(fwd_input_ready), 0);
        req = 4'b1001; txn(0, 0, 0, 1'b0);
        req = 4'b0010;
        for (int k = 0; k < 3; k++) txn(1, 0, 0, 1'b0);
        req = '0;
`ifdef BN_FWD_ARB_STATS_EN
        chk("stats1", int'(stats_grants[1]), 3);
        chk("stats0", int'(stats_grants[0]), 1);
`endif
        step(); step();
        chk("q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
